// File: rtl/mon_frame_rx_fifo.sv
// Serial frame receiver (start bit, DATA_WIDTH payload bits, stop bit) feeding
// a small FIFO with a valid/ready pop interface and sticky error flags.
module mon_frame_rx_fifo #(
    parameter int DATA_WIDTH = 40,
    parameter int DEPTH      = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                       mon_clk,
    input  logic                       rst,
    input  logic                       to_mon,
    input  logic                       err_clear,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    wr_req;
    logic                    bad_stop;
    logic                    full;
    logic                    pop;
    logic                    wr_en;
    logic                    drop;

    always_ff @(posedge mon_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (to_mon) next_state = DATA;
            DATA: if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) next_state = STOP;
            STOP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge mon_clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (MSB_FIRST != 0) begin
                        shift_reg <= {shift_reg[DATA_WIDTH-2:0], to_mon};
                    end else begin
                        shift_reg <= {to_mon, shift_reg[DATA_WIDTH-1:1]};
                    end
                end
                default: bit_cnt <= bit_cnt;
            endcase
        end
    end

    // A full FIFO still accepts a write when the head is popped on the same edge.
    assign busy      = (state != IDLE);
    assign wr_req    = (state == STOP) && !to_mon;
    assign bad_stop  = (state == STOP) && to_mon;
    assign out_valid = (fifo_level != '0);
    assign full      = (fifo_level == LVL_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign wr_en     = wr_req && (!full || pop);
    assign drop      = wr_req && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge mon_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge mon_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // A new error event on the same edge as err_clear keeps the flag set.
    always_ff @(posedge mon_clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (bad_stop)       frame_err <= 1'b1;
            else if (err_clear) frame_err <= 1'b0;
            if (drop)           overflow  <= 1'b1;
            else if (err_clear) overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mon_frame_rx_fifo.sv
// Directed bench for mon_frame_rx_fifo: MSB-first and LSB-first instances share
// the serial line; inputs change on the falling edge and outputs are checked there.
module tb_mon_frame_rx_fifo;

    logic        mon_clk = 1'b0;
    logic        rst;
    logic        to_mon;
    logic        err_clear;
    logic        out_ready;
    logic [39:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        frame_err;
    logic        overflow;
    logic [39:0] lsb_data;
    logic        lsb_valid;
    logic [2:0]  lsb_level;
    logic        lsb_busy;
    logic        lsb_ferr;
    logic        lsb_ovf;

    int tests = 0;
    int fails = 0;
    logic        capture_en = 1'b0;
    int          max_level  = 0;
    logic [39:0] got_q[$];

    mon_frame_rx_fifo #(.DATA_WIDTH(40), .DEPTH(4), .MSB_FIRST(1)) dut (
        .mon_clk(mon_clk), .rst(rst), .to_mon(to_mon), .err_clear(err_clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .busy(busy), .frame_err(frame_err), .overflow(overflow)
    );

    mon_frame_rx_fifo #(.DATA_WIDTH(40), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .mon_clk(mon_clk), .rst(rst), .to_mon(to_mon), .err_clear(err_clear),
        .out_data(lsb_data), .out_valid(lsb_valid), .out_ready(out_ready),
        .fifo_level(lsb_level), .busy(lsb_busy), .frame_err(lsb_ferr), .overflow(lsb_ovf)
    );

    always #5 mon_clk = ~mon_clk;

    always @(negedge mon_clk) begin
        if (capture_en) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] rev40(input logic [39:0] v);
        logic [39:0] r;
        for (int i = 0; i < 40; i++) r[i] = v[39-i];
        return r;
    endfunction

    function automatic logic [39:0] wrap_val(input int i);
        return {8'(i + 1), 32'hC0DE_0000 + 32'(i * 7)};
    endfunction

    // Start bit, 40 payload bits MSB first, stop bit; returns on the falling edge
    // right after the stop bit has been sampled.
    task automatic apply_stimulus(input logic [39:0] payload, input logic stop_bit,
                                  input logic ready_data, input logic ready_stop);
        out_ready = ready_data;
        to_mon = 1'b1;
        @(negedge mon_clk);
        for (int i = 39; i >= 0; i--) begin
            to_mon = payload[i];
            @(negedge mon_clk);
        end
        to_mon = stop_bit;
        out_ready = ready_stop;
        @(negedge mon_clk);
        to_mon = 1'b0;
        out_ready = ready_data;
    endtask

    task automatic check_output(input string tag, input logic [39:0] exp);
        check(tag, 64'(out_data), 64'(exp));
        out_ready = 1'b1;
        @(negedge mon_clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; to_mon = 1'b0; err_clear = 1'b0; out_ready = 1'b0;
        @(negedge mon_clk);
        @(negedge mon_clk);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);

        // Start bit presented on the very first edge after release
        rst = 1'b0;
        apply_stimulus(40'h12_3456_789A, 1'b0, 1'b0, 1'b0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'h12_3456_789A);
        check("single_level", 64'(fifo_level), 64'd1);
        check("single_lsb_data", 64'(lsb_data), 64'(rev40(40'h12_3456_789A)));
        check("single_busy", 64'(busy), 64'd0);
        check_output("single_pop", 40'h12_3456_789A);
        check("single_empty", 64'(out_valid), 64'd0);

        apply_stimulus(40'hFF_00FF_00FF, 1'b1, 1'b0, 1'b0);
        check("ferr_level", 64'(fifo_level), 64'd0);
        check("ferr_flag", 64'(frame_err), 64'd1);
        check("ferr_ovf", 64'(overflow), 64'd0);
        @(negedge mon_clk);
        check("ferr_no_restart", 64'(busy), 64'd0);
        err_clear = 1'b1;
        @(negedge mon_clk);
        err_clear = 1'b0;
        check("ferr_cleared", 64'(frame_err), 64'd0);
        out_ready = 1'b1;
        @(negedge mon_clk);
        out_ready = 1'b0;
        check("pop_empty_level", 64'(fifo_level), 64'd0);

        for (int k = 1; k <= 5; k++) apply_stimulus(40'(k), 1'b0, 1'b0, 1'b0);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_ferr", 64'(frame_err), 64'd0);
        @(negedge mon_clk);
        check("ovf_stable", 64'(out_data), 64'd1);
        for (int k = 1; k <= 4; k++) check_output("ovf_pop", 40'(k));
        check("ovf_drained", 64'(out_valid), 64'd0);
        err_clear = 1'b1;
        @(negedge mon_clk);
        err_clear = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        for (int k = 1; k <= 4; k++) apply_stimulus(40'(k), 1'b0, 1'b0, 1'b0);
        check("full_head", 64'(out_data), 64'd1);
        apply_stimulus(40'd5, 1'b0, 1'b0, 1'b1);
        check("fullpop_level", 64'(fifo_level), 64'd4);
        check("fullpop_ovf", 64'(overflow), 64'd0);
        for (int k = 2; k <= 5; k++) check_output("fullpop_pop", 40'(k));
        check("fullpop_drained", 64'(fifo_level), 64'd0);

        apply_stimulus(40'h11, 1'b0, 1'b0, 1'b0);
        apply_stimulus(40'h22, 1'b0, 1'b0, 1'b0);
        check("rstmid_level_before", 64'(fifo_level), 64'd2);
        to_mon = 1'b1;
        @(negedge mon_clk);
        for (int i = 0; i < 20; i++) @(negedge mon_clk);
        check("rstmid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid_level", 64'(fifo_level), 64'd0);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_data", 64'(out_data), 64'd0);
        @(negedge mon_clk);
        to_mon = 1'b0;
        rst = 1'b0;
        @(negedge mon_clk);
        @(negedge mon_clk);
        check("rstmid_idle", 64'(busy), 64'd0);
        apply_stimulus(40'hA5_A5A5_A5A5, 1'b0, 1'b0, 1'b0);
        check("rstmid_data_after", 64'(out_data), 64'hA5_A5A5_A5A5);
        check("rstmid_level_after", 64'(fifo_level), 64'd1);
        check("rstmid_lsb_data", 64'(lsb_data), 64'(rev40(40'hA5_A5A5_A5A5)));
        check_output("rstmid_pop", 40'hA5_A5A5_A5A5);

        out_ready = 1'b1;
        capture_en = 1'b1;
        @(negedge mon_clk);
        for (int i = 0; i < 10; i++) apply_stimulus(wrap_val(i), 1'b0, 1'b1, 1'b1);
        @(negedge mon_clk);
        @(negedge mon_clk);
        capture_en = 1'b0;
        out_ready = 1'b0;
        check("wrap_count", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check("wrap_data", 64'(got_q[i]), 64'(wrap_val(i)));
        end
        check("wrap_max_level", 64'(max_level), 64'd1);
        check("wrap_level_end", 64'(fifo_level), 64'd0);
        check("wrap_ferr", 64'(frame_err), 64'd0);
        check("wrap_ovf", 64'(overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
